// File: rtl/fp_mul_arbiter.sv
// Round-robin arbiter sharing one multi-cycle FP multiplier
// among N requesters, with response backpressure and timeout.
module fp_mul_arbiter #(
  parameter int N = 4,
  parameter int TIMEOUT = 64,
  localparam int ID_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req_valid_i,
  input  logic [N*32-1:0] req_a_i,
  input  logic [N*32-1:0] req_b_i,
  output logic [N-1:0]    req_ready_o,
  output logic            mul_start_o,
  output logic [31:0]     mul_a_o,
  output logic [31:0]     mul_b_o,
  input  logic            mul_done_i,
  input  logic [31:0]     mul_product_i,
  input  logic [3:0]      mul_flags_i,
  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic [ID_W-1:0] rsp_id_o,
  output logic [31:0]     rsp_product_o,
  output logic [3:0]      rsp_flags_o,
  output logic            rsp_timeout_o,
  output logic            busy_o
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [ID_W-1:0] r_rr;
  logic [ID_W-1:0] r_id;
  logic [31:0]     r_a;
  logic [31:0]     r_b;
  logic [31:0]     r_prod;
  logic [3:0]      r_flags;
  logic            r_tmo;
  logic [TW-1:0]   r_tmr;
  logic [TW-1:0]   w_tmr_inc;
  logic            w_tmo;
  logic            w_found;
  logic [ID_W-1:0] w_win;
  logic [31:0]     w_a;
  logic [31:0]     w_b;

  assign w_tmr_inc = r_tmr + 1'b1;
  assign w_tmo     = (w_tmr_inc == TW'(TIMEOUT - 1));

  // search upward from r_rr, wrapping past N-1
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_a     = '0;
    w_b     = '0;
    for (int k = 0; k < N; k++) begin
      int j;
      j = int'(r_rr) + k;
      if (j >= N) j = j - N;
      if (!w_found && req_valid_i[j]) begin
        w_found = 1'b1;
        w_win   = ID_W'(j);
        w_a     = req_a_i[32*j +: 32];
        w_b     = req_b_i[32*j +: 32];
      end
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    req_ready_o   = '0;
    mul_start_o   = 1'b0;
    mul_a_o       = '0;
    mul_b_o       = '0;
    rsp_valid_o   = 1'b0;
    rsp_id_o      = '0;
    rsp_product_o = '0;
    rsp_flags_o   = '0;
    rsp_timeout_o = 1'b0;
    busy_o        = (r_state != S_IDLE);
    unique case (r_state)
      S_IDLE: begin
        if (w_found && rst_n) begin
          req_ready_o = N'(1) << w_win;
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        mul_start_o = 1'b1;
        mul_a_o     = r_a;
        mul_b_o     = r_b;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        mul_a_o = r_a;
        mul_b_o = r_b;
        if (mul_done_i || w_tmo)
          w_state_nxt = S_RESP;
      end
      S_RESP: begin
        rsp_valid_o   = 1'b1;
        rsp_id_o      = r_id;
        rsp_product_o = r_prod;
        rsp_flags_o   = r_flags;
        rsp_timeout_o = r_tmo;
        if (rsp_ready_i)
          w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr    <= '0;
      r_id    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_prod  <= '0;
      r_flags <= '0;
      r_tmo   <= 1'b0;
      r_tmr   <= '0;
    end else begin
      if (r_state == S_IDLE && w_found) begin
        r_id <= w_win;
        r_a  <= w_a;
        r_b  <= w_b;
      end
      if (r_state == S_ISSUE)
        r_tmr <= '0;
      if (r_state == S_WAIT) begin
        r_tmr <= w_tmr_inc;
        // done has priority over a coincident timeout
        if (mul_done_i) begin
          r_prod  <= mul_product_i;
          r_flags <= mul_flags_i;
          r_tmo   <= 1'b0;
        end else if (w_tmo) begin
          r_prod  <= '0;
          r_flags <= '0;
          r_tmo   <= 1'b1;
        end
      end
      if (r_state == S_RESP && rsp_ready_i)
        r_rr <= (r_id == ID_W'(N - 1)) ? '0 : r_id + 1'b1;
    end
  end

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Directed bench for fp_mul_arbiter: grant order, latency,
// timeout, done/timeout coincidence, backpressure, reset.
module tb_fp_mul_arbiter;

  localparam int N = 4;
  localparam int ID_W = 2;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    req_valid_i;
  logic [N*32-1:0] req_a_i;
  logic [N*32-1:0] req_b_i;
  logic [N-1:0]    req_ready_o;
  logic            mul_start_o;
  logic [31:0]     mul_a_o;
  logic [31:0]     mul_b_o;
  logic            mul_done_i;
  logic [31:0]     mul_product_i;
  logic [3:0]      mul_flags_i;
  logic            rsp_valid_o;
  logic            rsp_ready_i;
  logic [ID_W-1:0] rsp_id_o;
  logic [31:0]     rsp_product_o;
  logic [3:0]      rsp_flags_o;
  logic            rsp_timeout_o;
  logic            busy_o;

  int total = 0;
  int bad = 0;

  fp_mul_arbiter #(.N(N), .TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid_i),
    .req_a_i(req_a_i), .req_b_i(req_b_i),
    .req_ready_o(req_ready_o),
    .mul_start_o(mul_start_o),
    .mul_a_o(mul_a_o), .mul_b_o(mul_b_o),
    .mul_done_i(mul_done_i),
    .mul_product_i(mul_product_i),
    .mul_flags_i(mul_flags_i),
    .rsp_valid_o(rsp_valid_o),
    .rsp_ready_i(rsp_ready_i),
    .rsp_id_o(rsp_id_o),
    .rsp_product_o(rsp_product_o),
    .rsp_flags_o(rsp_flags_o),
    .rsp_timeout_o(rsp_timeout_o),
    .busy_o(busy_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no_finish want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Entered just after a negedge in IDLE with requests driven.
  // done is driven in the lat-th WAIT cycle.
  task automatic serve(input int id, input int lat,
                       input logic [31:0] p,
                       input logic [3:0] f);
    chk("grant", 32'(req_ready_o), 32'(1) << id);
    @(negedge clk); #1;
    chk("start", 32'(mul_start_o), 1);
    chk("opa", mul_a_o, 32'hA0 + 32'(id));
    chk("opb", mul_b_o, 32'hB0 + 32'(id));
    for (int c = 1; c <= lat; c++) begin
      @(negedge clk);
      if (c == lat) begin
        mul_done_i    = 1'b1;
        mul_product_i = p;
        mul_flags_i   = f;
      end
      #1;
    end
    @(negedge clk);
    mul_done_i = 1'b0;
    #1;
    chk("rvalid", 32'(rsp_valid_o), 1);
    chk("rid", 32'(rsp_id_o), 32'(id));
    chk("rprod", rsp_product_o, p);
    chk("rflags", 32'(rsp_flags_o), 32'(f));
    chk("rtmo", 32'(rsp_timeout_o), 0);
    chk("nogrant", 32'(req_ready_o), 0);
    rsp_ready_i = 1'b1;
    @(negedge clk);
    rsp_ready_i = 1'b0;
    #1;
  endtask

  initial begin
    int n;
    rst_n         = 1'b0;
    req_valid_i   = 4'hF;
    req_a_i       = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    req_b_i       = {32'hB3, 32'hB2, 32'hB1, 32'hB0};
    mul_done_i    = 1'b0;
    mul_product_i = '0;
    mul_flags_i   = '0;
    rsp_ready_i   = 1'b0;
    #1;
    chk("rst_ready", 32'(req_ready_o), 0);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_rvalid", 32'(rsp_valid_o), 0);
    chk("rst_start", 32'(mul_start_o), 0);
    req_valid_i = '0;
    @(negedge clk);
    rst_n = 1'b1;

    // single request, done 3 cycles after start
    @(negedge clk);
    req_valid_i = 4'b0001;
    req_a_i[31:0] = 32'h40000000;
    req_b_i[31:0] = 32'h40400000;
    #1;
    chk("s_grant", 32'(req_ready_o), 1);
    chk("s_idle_a", mul_a_o, 0);
    @(negedge clk);
    req_valid_i = '0;
    #1;
    chk("s_start", 32'(mul_start_o), 1);
    chk("s_opa", mul_a_o, 32'h40000000);
    chk("s_opb", mul_b_o, 32'h40400000);
    chk("s_busy", 32'(busy_o), 1);
    @(negedge clk); #1;
    chk("s_start_off", 32'(mul_start_o), 0);
    @(negedge clk);
    @(negedge clk);
    mul_done_i    = 1'b1;
    mul_product_i = 32'h40C00000;
    mul_flags_i   = 4'h0;
    #1;
    chk("s_rv_early", 32'(rsp_valid_o), 0);
    @(negedge clk);
    mul_done_i = 1'b0;
    #1;
    chk("s_rvalid", 32'(rsp_valid_o), 1);
    chk("s_rid", 32'(rsp_id_o), 0);
    chk("s_rprod", rsp_product_o, 32'h40C00000);
    chk("s_rflags", 32'(rsp_flags_o), 0);
    chk("s_rtmo", 32'(rsp_timeout_o), 0);
    rsp_ready_i = 1'b1;
    @(negedge clk);
    rsp_ready_i = 1'b0;
    #1;
    chk("s_idle", 32'(busy_o), 0);

    // reset then fairness from requester 0
    rst_n = 1'b0;
    req_a_i = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    req_b_i = {32'hB3, 32'hB2, 32'hB1, 32'hB0};
    @(negedge clk);
    rst_n = 1'b1;
    req_valid_i = 4'hF;
    #1;
    for (int i = 0; i < 8; i++)
      serve(i % 4, 1 + i % 3, 32'h3F800000 + 32'(i), 4'(i));

    // timeout: requester 2 alone, no done
    req_valid_i = 4'b0100;
    #1;
    chk("t_grant", 32'(req_ready_o), 4);
    @(negedge clk);
    req_valid_i = '0;
    #1;
    chk("t_start", 32'(mul_start_o), 1);
    n = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk); #1;
      n++;
      if (rsp_valid_o) break;
    end
    chk("t_lat", 32'(n), 8);
    chk("t_tmo", 32'(rsp_timeout_o), 1);
    chk("t_prod", rsp_product_o, 0);
    chk("t_flags", 32'(rsp_flags_o), 0);
    chk("t_id", 32'(rsp_id_o), 2);
    rsp_ready_i = 1'b1;
    @(negedge clk);
    rsp_ready_i = 1'b0;

    // done coincides with the final timer value
    req_valid_i = 4'b1000;
    #1;
    serve(3, 7, 32'h40490FDB, 4'b0010);
    req_valid_i = 4'b0001;
    #1;

    // backpressure with stray done during RESP
    chk("b_grant", 32'(req_ready_o), 1);
    @(negedge clk);
    req_valid_i = 4'hF;
    #1;
    chk("b_start", 32'(mul_start_o), 1);
    @(negedge clk);
    mul_done_i    = 1'b1;
    mul_product_i = 32'h41200000;
    mul_flags_i   = 4'b1000;
    @(negedge clk);
    for (int r = 1; r <= 6; r++) begin
      mul_done_i    = (r == 3);
      mul_product_i = 32'hDEADBEEF;
      mul_flags_i   = 4'hF;
      rsp_ready_i   = (r == 6);
      #1;
      chk("b_rvalid", 32'(rsp_valid_o), 1);
      chk("b_rprod", rsp_product_o, 32'h41200000);
      chk("b_rflags", 32'(rsp_flags_o), 32'h8);
      chk("b_nogrant", 32'(req_ready_o), 0);
      @(negedge clk);
    end
    mul_done_i  = 1'b0;
    rsp_ready_i = 1'b0;
    #1;
    chk("b_idle", 32'(busy_o), 0);
    chk("b_next", 32'(req_ready_o), 2);

    // reset while in WAIT
    @(negedge clk); #1;
    chk("r_start", 32'(mul_start_o), 1);
    chk("r_opa", mul_a_o, 32'hA1);
    @(negedge clk); #1;
    chk("r_wait", 32'(busy_o), 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("r_busy", 32'(busy_o), 0);
    chk("r_opa0", mul_a_o, 0);
    chk("r_ready", 32'(req_ready_o), 0);
    chk("r_rvalid", 32'(rsp_valid_o), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("r_first", 32'(req_ready_o), 1);
    req_valid_i = '0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fp_mul_arbiter.md
FP_MUL_ARBITER -- requirements
Module: fp_mul_arbiter

Interface
REQ-001 Parameter: N, 4, number of requesters sharing one multiplier32FP instance (2..8).
REQ-002 Parameter: TIMEOUT, 64, maximum cycles in WAIT before the transaction is aborted (>=4).
REQ-003 Derived constant: ID_W = max(1, clog2(N)).
REQ-004 Clock and reset: clk is the clock; rst_n is the reset, asynchronous, active-low.
REQ-005 Port: clk  in  1  clock.
REQ-006 Port: rst_n  in  1  async active-low reset.
REQ-007 Port: req_valid_i  in  N  per-requester operation request.
REQ-008 Port: req_a_i  in  N*32  packed operand A; slice i = [32*i+31:32*i].
REQ-009 Port: req_b_i  in  N*32  packed operand B; same slicing.
REQ-010 Port: req_ready_o  out  N  one-hot accept; a request transfers when valid&ready.
REQ-011 Port: mul_start_o  out  1  one-cycle start pulse to the multiplier.
REQ-012 Port: mul_a_o, mul_b_o  out  32 each  operands to the multiplier.
REQ-013 Port: mul_done_i  in  1  multiplier completion pulse.
REQ-014 Port: mul_product_i  in  32  product, valid in the mul_done_i cycle.
REQ-015 Port: mul_flags_i  in  4  {nan, infinite, overflow, underflow}, valid with mul_done_i.
REQ-016 Port: rsp_valid_o  out  1  response valid, held until accepted.
REQ-017 Port: rsp_ready_i  in  1  response accept.
REQ-018 Port: rsp_id_o  out  ID_W  index of the requester served.
REQ-019 Port: rsp_product_o  out  32  result.
REQ-020 Port: rsp_flags_o  out  4  captured mul_flags_i.
REQ-021 Port: rsp_timeout_o  out  1  transaction aborted by timeout.
REQ-022 Port: busy_o  out  1  high in any state other than IDLE.

Function
REQ-023 FSM states SHALL be IDLE, ISSUE, WAIT and RESP; only one transaction SHALL be in flight.
REQ-024 IDLE: if any req_valid_i is set, the FSM SHALL select a winner round-robin, searching from rr_ptr upward with wrap at N-1, assert req_ready_o[winner] combinationally for that cycle only, latch its operands and ID, and go to ISSUE.
REQ-025 req_ready_o SHALL be all zero in every state other than IDLE and in IDLE when no request is valid.
REQ-026 ISSUE: mul_start_o SHALL be 1 for exactly this cycle; the timer SHALL clear to 0; the next state SHALL be WAIT.
REQ-027 mul_a_o and mul_b_o SHALL drive the latched operands, stable from ISSUE through the end of WAIT, and SHALL be 0 in IDLE.
REQ-028 WAIT: the timer SHALL increment each cycle; on mul_done_i the block SHALL capture product and flags, clear rsp_timeout_o, and go to RESP.
REQ-029 WAIT: if the timer reaches TIMEOUT-1 without mul_done_i, the block SHALL set rsp_timeout_o=1, product=0, flags=0, and go to RESP.
REQ-030 If mul_done_i and the timeout coincide in the same cycle, done SHALL win and the timeout SHALL NOT be reported.
REQ-031 mul_done_i outside WAIT SHALL be ignored.
REQ-032 RESP: rsp_valid_o SHALL be 1 with rsp_id_o, rsp_product_o, rsp_flags_o and rsp_timeout_o stable until rsp_ready_i=1.
REQ-033 On the RESP handshake, rr_ptr SHALL become (served ID + 1) mod N and the FSM SHALL return to IDLE; the next grant SHALL occur no earlier than the following cycle.
REQ-034 Latency: for a request accepted in cycle T, mul_start_o SHALL pulse at T+1, and rsp_valid_o SHALL rise the cycle after mul_done_i, at T+3 at the earliest.
REQ-035 A requester dropping req_valid_i after acceptance SHALL NOT affect the in-flight transaction.

Reset
REQ-036 On rst_n low, at any time including mid-transaction, the block SHALL enter IDLE, set rr_ptr=0 and timer=0, and drive all outputs to 0; any in-flight result SHALL be discarded.
REQ-037 After reset release, the first grant SHALL follow priority from requester 0.

Verification
REQ-038 Single request: req_valid_i=0001, A=0x40000000, B=0x40400000, done after 3 cycles with product 0x40C00000 -> ready pulse on requester 0; start at T+1; rsp_id_o=0, rsp_product_o=0x40C00000, rsp_flags_o=0.
REQ-039 Fairness: req_valid_i=1111 held for 8 transactions -> service order 0,1,2,3,0,1,2,3.
REQ-040 Timeout: TIMEOUT=8, mul_done_i never asserted -> rsp_valid_o 8 cycles after ISSUE with rsp_timeout_o=1 and rsp_product_o=0.
REQ-041 Coincidence: mul_done_i in the same cycle the timer reaches TIMEOUT-1 -> rsp_timeout_o=0 and the product is captured.
REQ-042 Backpressure: rsp_ready_i held 0 for 5 cycles, then set to 1 -> response stable for 6 cycles, no grant meanwhile, and stray mul_done_i ignored.
REQ-043 Reset in WAIT -> all outputs 0 next cycle, busy_o=0, and the next grant goes to requester 0.
